// File: rtl/tx_byte_serializer.sv
// rtl/tx_byte_serializer.sv - FIFO word to MSB-first byte serializer with block counting
module tx_byte_serializer #(
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        tx_deq_word,
    input  logic        flush,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        block_done,
    output logic        busy
);
    localparam int CW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          accept;
    logic          last_accept;
    logic          load;

    assign accept      = (state_q == SEND) & byte_ready;
    assign last_accept = accept & (idx_q == 2'd3);
    // Refilling on the fourth-byte accept keeps the stream bubble-free.
    assign load        = !flush & !fifo_empty & ((state_q == IDLE) | last_accept);

    assign tx_deq_word = load;
    assign byte_valid  = (state_q == SEND);
    assign busy        = (state_q == SEND);
    assign block_done  = done_q;

    always_comb begin
        byte_out = word_q[31:24];
        case (idx_q)
            2'd1:    byte_out = word_q[23:16];
            2'd2:    byte_out = word_q[15:8];
            2'd3:    byte_out = word_q[7:0];
            default: byte_out = word_q[31:24];
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            if (accept && (idx_q != 2'd3)) begin
                idx_d = idx_q + 2'd1;
            end
            if (last_accept) begin
                state_d = IDLE;
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (load) begin
                word_d  = fifo_data;
                idx_d   = 2'd0;
                state_d = SEND;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_tx_byte_serializer.sv
// tb/tb_tx_byte_serializer.sv - scoreboard bench for tx_byte_serializer
module tb_tx_byte_serializer;
    localparam int WPB = 4;

    logic        tb_clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'hDEAD_BEEF;
    logic        tx_deq_word;
    logic        flush = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        block_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    bit          pop_pending = 0;
    int          pop_cnt = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          byte_pos = 0;
    int          wc_model = 0;
    bit          done_exp = 0;

    tx_byte_serializer #(.WORDS_PER_BLOCK(WPB)) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .tx_deq_word(tx_deq_word),
        .flush      (flush),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .block_done (block_done),
        .busy       (busy)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        refresh();
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // FIFO model: the head advances just after the edge where a pop was seen.
    always @(posedge tb_clk) begin
        #1;
        if (pop_pending) begin
            pop_pending = 0;
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty: got pop with 0 words, required no pop");
            end else begin
                void'(fifo_q.pop_front());
            end
            refresh();
        end
    end

    // Scoreboard monitor: accepted bytes and block_done pulses against the model.
    always @(negedge tb_clk) begin
        if (n_rst) begin
            checks++;
            if (block_done !== done_exp) begin
                errors++;
                $display("FAIL block_done_cycle: got %b, required %b (t=%0t)", block_done, done_exp, $time);
            end
            done_exp = 0;
            if (block_done) done_cnt++;
            if (tx_deq_word) begin
                pop_pending = 1;
                pop_cnt++;
            end
            if (flush) begin
                if (byte_valid) begin
                    repeat (4 - byte_pos) if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                byte_pos = 0;
                wc_model = 0;
            end else if (byte_valid && byte_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte_extra: got %h, required no byte", byte_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (byte_out !== e) begin
                        errors++;
                        $display("FAIL byte_value: got %h, required %h (t=%0t)", byte_out, e, $time);
                    end
                end
                acc_cnt++;
                if (byte_pos == 3) begin
                    byte_pos = 0;
                    if (wc_model == WPB - 1) begin
                        wc_model = 0;
                        done_exp = 1;
                    end else begin
                        wc_model++;
                    end
                end else begin
                    byte_pos++;
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge tb_clk);
            if (exp_q.size() == 0 && !byte_valid) break;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes left, required 0", exp_q.size());
        end
        step();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            checks++;
            if ({byte_valid, busy, tx_deq_word, block_done, byte_out} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs: got v=%b b=%b d=%b bd=%b o=%h, required all 0",
                         byte_valid, busy, tx_deq_word, block_done, byte_out);
            end
        end
        step();
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            checks++;
            if ({byte_valid, busy, tx_deq_word} !== 3'b000) begin
                errors++;
                $display("FAIL idle_empty: got v=%b b=%b d=%b, required 000", byte_valid, busy, tx_deq_word);
            end
        end
        step();
    endtask

    task automatic test_single_word();
        push_word(32'hAABBCCDD);
        byte_ready = 1'b1;
        @(negedge tb_clk);
        checks++;
        if (tx_deq_word !== 1'b1 || byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_load: got deq=%b v=%b, required deq=1 v=0", tx_deq_word, byte_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_clk);
            checks++;
            if (byte_valid !== 1'b1 || tx_deq_word !== 1'b0) begin
                errors++;
                $display("FAIL single_stream: byte %0d got v=%b deq=%b, required v=1 deq=0", i, byte_valid, tx_deq_word);
            end
        end
        @(negedge tb_clk);
        checks++;
        if (byte_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got v=%b busy=%b, required 0 0", byte_valid, busy);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pop_cnt;
        push_word(32'h30313233);
        push_word(32'h34353637);
        @(negedge tb_clk);
        checks++;
        if (tx_deq_word !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_pop: got %b, required 1", tx_deq_word);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge tb_clk);
            checks++;
            if (byte_valid !== 1'b1 || tx_deq_word !== (i == 3)) begin
                errors++;
                $display("FAIL b2b_stream: byte %0d got v=%b deq=%b, required v=1 deq=%b", i, byte_valid, tx_deq_word, i == 3);
            end
        end
        wait_drain(10);
        checks++;
        if (pop_cnt - p0 !== 2) begin
            errors++;
            $display("FAIL b2b_pops: got %0d, required 2", pop_cnt - p0);
        end
    endtask

    task automatic test_backpressure();
        int a0, p0;
        a0 = acc_cnt;
        p0 = pop_cnt;
        push_word(32'hAABBCCDD);
        push_word(32'h55667788);
        byte_ready = 1'b1;
        @(negedge tb_clk);
        @(negedge tb_clk);
        step();
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            checks++;
            if (byte_out !== 8'hBB || byte_valid !== 1'b1 || tx_deq_word !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got o=%h v=%b deq=%b, required BB 1 0", byte_out, byte_valid, tx_deq_word);
            end
        end
        step();
        byte_ready = 1'b1;
        wait_drain(20);
        checks++;
        if (acc_cnt - a0 !== 8 || pop_cnt - p0 !== 2) begin
            errors++;
            $display("FAIL bp_counts: got bytes=%0d pops=%0d, required 8 2", acc_cnt - a0, pop_cnt - p0);
        end
    endtask

    task automatic test_block_count();
        int d0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        d0 = done_cnt;
        push_word(32'h30313233);
        push_word(32'h34353637);
        push_word(32'h38394142);
        push_word(32'h43444546);
        wait_drain(30);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL block_one: got %0d pulses, required 1", done_cnt - d0);
        end
        d0 = done_cnt;
        push_word(32'h01020304);
        wait_drain(20);
        checks++;
        if (done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL block_partial: got %0d pulses, required 0", done_cnt - d0);
        end
        for (int i = 0; i < 3; i++) push_word($urandom);
        wait_drain(30);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL block_second: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_flush();
        int d0;
        d0 = done_cnt;
        push_word(32'hAABBCCDD);
        push_word(32'h11223344);
        byte_ready = 1'b1;
        @(negedge tb_clk);
        @(negedge tb_clk);
        @(negedge tb_clk);
        step();
        flush = 1'b1;
        @(negedge tb_clk);
        checks++;
        if (byte_out !== 8'hCC || tx_deq_word !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got o=%h deq=%b, required CC 0", byte_out, tx_deq_word);
        end
        step();
        flush = 1'b0;
        @(negedge tb_clk);
        checks++;
        if (byte_valid !== 1'b0 || busy !== 1'b0 || tx_deq_word !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: got v=%b busy=%b deq=%b, required 0 0 1", byte_valid, busy, tx_deq_word);
        end
        wait_drain(20);
        for (int i = 0; i < 2; i++) push_word($urandom);
        wait_drain(20);
        checks++;
        if (done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL flush_cnt_early: got %0d pulses, required 0", done_cnt - d0);
        end
        push_word(32'hFEEDF00D);
        wait_drain(20);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL flush_cnt_restart: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        push_word(32'hAABBCCDD);
        byte_ready = 1'b0;
        @(negedge tb_clk);
        step();
        #2;
        n_rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        pop_pending = 0;
        byte_pos = 0;
        wc_model = 0;
        done_exp = 0;
        refresh();
        #1;
        checks++;
        if ({byte_valid, busy, block_done, tx_deq_word} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got v=%b busy=%b bd=%b deq=%b, required 0000", byte_valid, busy, block_done, tx_deq_word);
        end
        step();
        step();
        n_rst = 1'b1;
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_clk);
            checks++;
            if ({byte_valid, busy, tx_deq_word} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle: got v=%b busy=%b deq=%b, required 000", byte_valid, busy, tx_deq_word);
            end
        end
        step();
    endtask

    initial begin
        refresh();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_block_count();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
